// File: rtl/load_unit.sv
// load_unit: multicycle load engine. Issues a word-aligned read,
// waits for a variable-latency ack, then extracts and extends the
// byte/halfword/word into a held result register.
// Ports: clk, rst (async, high); req/addr/ldtype request;
// busy/done/err status; data result;
// mem_addr/mem_rd/mem_ack/mem_rdata memory side.
module load_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [2:0]  ldtype,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] data,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [2:0] LW  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LHU = 3'b010;
  localparam logic [2:0] LB  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_n;
  logic [7:0]  cnt;
  logic [1:0]  off;
  logic [2:0]  typ;
  logic        legal;
  logic        tmo;

  // Alignment and type check on the request as presented.
  always_comb begin
    legal = 1'b0;
    unique case (ldtype)
      LW:      legal = (addr[1:0] == 2'b00);
      LH, LHU: legal = (addr[0] == 1'b0);
      LB, LBU: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign tmo = (cnt == CNT_LAST);

  // Big-endian lane select followed by sign/zero extension.
  function automatic logic [31:0] extract(
    input logic [31:0] w,
    input logic [1:0]  o,
    input logic [2:0]  t
  );
    logic [7:0]  b;
    logic [15:0] h;
    unique case (o)
      2'd0: b = w[31:24];
      2'd1: b = w[23:16];
      2'd2: b = w[15:8];
      default: b = w[7:0];
    endcase
    h = o[1] ? w[15:0] : w[31:16];
    unique case (t)
      LH:      extract = {{16{h[15]}}, h};
      LHU:     extract = {16'h0, h};
      LB:      extract = {{24{b[7]}}, b};
      LBU:     extract = {24'h0, b};
      default: extract = w;
    endcase
  endfunction

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (req) state_n = legal ? S_WAIT : S_ERR;
      end
      S_WAIT: begin
        // ack takes priority over an expiring counter
        if (mem_ack)  state_n = S_DONE;
        else if (tmo) state_n = S_ERR;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 8'd0;
      off      <= 2'd0;
      typ      <= 3'd0;
      mem_addr <= 32'h0;
      data     <= 32'h0;
    end else begin
      state <= state_n;
      if (state == S_WAIT) cnt <= cnt + 8'd1;
      else                 cnt <= 8'd0;
      if (state == S_IDLE && req) begin
        off      <= addr[1:0];
        typ      <= ldtype;
        mem_addr <= {addr[31:2], 2'b00};
      end
      if (state == S_WAIT && mem_ack)
        data <= extract(mem_rdata, off, typ);
    end
  end

  // Status decoded from state only, so reset clears them at once.
  assign busy   = (state != S_IDLE);
  assign mem_rd = (state == S_WAIT);
  assign done   = (state == S_DONE);
  assign err    = (state == S_ERR);

endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: table vectors, random loads against an arithmetic
// reference model, and reset corner sequences for load_unit.
module tb_load_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [2:0]  ldtype = 3'd0;
  logic        busy, done, err, mem_rd;
  logic [31:0] data, mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_data = 32'h0;

  always #5 clk = ~clk;

  load_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr),
    .ldtype(ldtype), .busy(busy), .done(done), .err(err),
    .data(data), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: size from type, legality by modulo, value by shifting.
  function automatic int ld_size(input logic [2:0] t);
    if (t == 3'd0) return 4;
    if (t <= 3'd2) return 2;
    return 1;
  endfunction

  function automatic bit ref_legal(input logic [31:0] a,
                                   input logic [2:0] t);
    if (t > 3'd4) return 0;
    return (a % ld_size(t)) == 0;
  endfunction

  function automatic logic [31:0] ref_val(input logic [31:0] a,
                                          input logic [2:0] t,
                                          input logic [31:0] w);
    longint v;
    longint m;
    int sz;
    sz = ld_size(t);
    v = longint'(w) >> ((4 - sz - int'(a % 4)) * 8);
    m = longint'(1) << (8 * sz);
    v = v % m;
    if ((t == 3'd1 || t == 3'd3) && v >= m / 2) v = v - m;
    return v[31:0];
  endfunction

  // Starts #1 after a posedge; ends #1 after the posedge that
  // re-enters IDLE. dly = WAIT cycle carrying the ack, 0 = never.
  task automatic run_load(input logic [31:0] a,
                          input logic [2:0] t,
                          input logic [31:0] w,
                          input int dly,
                          input bit noise,
                          output int kind,
                          output int cyc,
                          output int rd,
                          output bit aok,
                          output bit iok,
                          output logic [31:0] got);
    kind = 0; cyc = 0; rd = 0; aok = 1;
    req = 1'b1; addr = a; ldtype = t; mem_rdata = w;
    @(posedge clk); #1;
    req = 1'b0;
    for (int c = 1; c <= TO + 20; c++) begin
      @(negedge clk);
      if (mem_rd) begin
        rd++;
        if (mem_addr !== {a[31:2], 2'b00}) aok = 0;
      end
      if (done || err) begin
        kind = (done && err) ? 3 : (done ? 1 : 2);
        cyc = c;
        break;
      end
      mem_ack = mem_rd ? (rd == dly)
                       : (noise ? 1'($urandom % 2) : 1'b0);
      mem_rdata = (mem_rd && rd == dly) ? w : $urandom;
      req = (noise && busy) ? 1'($urandom % 2) : 1'b0;
      addr = noise ? $urandom : a;
    end
    mem_ack = 1'b0;
    req = 1'b0;
    @(negedge clk);
    iok = !busy && !done && !err && !mem_rd;
    got = data;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [2:0]  t;
    logic [31:0] w;
    int          dly;
    int          kind;
    int          cyc;
    int          rd;
    logic [31:0] data;
  } vec_t;

  vec_t vt[12];

  initial begin
    int kind, cyc, rd;
    bit aok, iok;
    logic [31:0] got;

    vt[0]  = '{32'h100, 3'd0, 32'hDEADBEEF, 1, 1, 2, 1, 32'hDEADBEEF};
    vt[1]  = '{32'h100, 3'd3, 32'h80F17F01, 3, 1, 4, 3, 32'hFFFFFF80};
    vt[2]  = '{32'h101, 3'd4, 32'h80F17F01, 3, 1, 4, 3, 32'h000000F1};
    vt[3]  = '{32'h102, 3'd3, 32'h80F17F01, 3, 1, 4, 3, 32'h0000007F};
    vt[4]  = '{32'h102, 3'd1, 32'h80F17F01, 3, 1, 4, 3, 32'h00007F01};
    vt[5]  = '{32'h100, 3'd2, 32'h80F17F01, 3, 1, 4, 3, 32'h000080F1};
    vt[6]  = '{32'h102, 3'd0, 32'h11111111, 1, 2, 1, 0, 32'h000080F1};
    vt[7]  = '{32'h101, 3'd1, 32'h22222222, 1, 2, 1, 0, 32'h000080F1};
    vt[8]  = '{32'h100, 3'd6, 32'h33333333, 1, 2, 1, 0, 32'h000080F1};
    vt[9]  = '{32'h200, 3'd0, 32'h44444444, 0, 2, 5, 4, 32'h000080F1};
    vt[10] = '{32'h204, 3'd0, 32'hCAFEF00D, 4, 1, 5, 4, 32'hCAFEF00D};
    vt[11] = '{32'h203, 3'd4, 32'h12345678, 2, 1, 3, 2, 32'h00000078};

    #3;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_flags", {29'h0, done, err, mem_rd}, 32'h0);
    check("rst_data", data, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_quiet", {30'h0, busy, mem_rd}, 32'h0);
    end
    @(posedge clk); #1;

    foreach (vt[i]) begin
      run_load(vt[i].a, vt[i].t, vt[i].w, vt[i].dly, 1'b0,
               kind, cyc, rd, aok, iok, got);
      check($sformatf("vec%0d_kind", i), kind, vt[i].kind);
      check($sformatf("vec%0d_cyc", i), cyc, vt[i].cyc);
      check($sformatf("vec%0d_rd", i), rd, vt[i].rd);
      check($sformatf("vec%0d_data", i), got, vt[i].data);
      check($sformatf("vec%0d_addr", i), {31'h0, aok}, 32'h1);
      check($sformatf("vec%0d_idle", i), {31'h0, iok}, 32'h1);
    end
    exp_data = vt[11].data;

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a, w;
      logic [2:0] t;
      int dly, ek, ec, er;
      a = $urandom;
      w = $urandom;
      t = ($urandom % 4 == 0) ? 3'($urandom_range(5, 7))
                              : 3'($urandom_range(0, 4));
      if ($urandom % 2 == 0 && t <= 3'd4)
        a = a & ~32'(ld_size(t) - 1);
      dly = $urandom_range(0, TO + 2);
      if (!ref_legal(a, t)) begin
        ek = 2; ec = 1; er = 0;
      end else if (dly >= 1 && dly <= TO) begin
        ek = 1; ec = dly + 1; er = dly;
        exp_data = ref_val(a, t, w);
      end else begin
        ek = 2; ec = TO + 1; er = TO;
      end
      run_load(a, t, w, dly, 1'b1, kind, cyc, rd, aok, iok, got);
      check($sformatf("rnd%0d_kind", i), kind, ek);
      check($sformatf("rnd%0d_cyc", i), cyc, ec);
      check($sformatf("rnd%0d_rd", i), rd, er);
      check($sformatf("rnd%0d_data", i), got, exp_data);
      check($sformatf("rnd%0d_addr", i), {31'h0, aok}, 32'h1);
      check($sformatf("rnd%0d_idle", i), {31'h0, iok}, 32'h1);
    end

    req = 1'b1; addr = 32'h300; ldtype = 3'd0;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    check("mid_rd_before", {31'h0, mem_rd}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_rd", {30'h0, mem_rd, busy}, 32'h0);
    check("mid_rst_flags", {30'h0, done, err}, 32'h0);
    check("mid_rst_data", data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_quiet", {29'h0, busy, done, err}, 32'h0);
    end
    mem_ack = 1'b0;
    @(posedge clk); #1;
    run_load(32'h308, 3'd0, 32'h0BADC0DE, 2, 1'b0,
             kind, cyc, rd, aok, iok, got);
    check("after_rst_kind", kind, 1);
    check("after_rst_cyc", cyc, 3);
    check("after_rst_data", got, 32'h0BADC0DE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_unit.md
# load_unit

Multicycle load engine for the AAI CPU datapath. It accepts a load request (address plus MIPS load type) from the control FSM and issues a word-aligned read to data memory. It waits for a variable-latency acknowledge, then extracts and extends the byte, halfword or word into a held 32-bit result register. It is the read-side counterpart of the CE-gated 32-bit state registers: they capture values on enable, this block fetches values back out of memory and presents them with a done/err handshake.

## Interface
- TIMEOUT, default 255: maximum number of WAIT cycles before the load is aborted (range 1..255).
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  start a load; sampled only in IDLE.
- addr  in  32  byte address of the load; sampled with req.
- ldtype  in  3  load type: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; 101–111 illegal.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse, load completed, data valid.
- err  out  1  one-cycle pulse, load rejected or timed out.
- data  out  32  load result, held until next successful load.
- mem_addr  out  32  word address to memory, {addr[31:2],2'b00}.
- mem_rd  out  1  read strobe, high for the whole WAIT state.
- mem_ack  in  1  memory acknowledge, mem_rdata valid when high.
- mem_rdata  in  32  memory read word.

## Operation
- States: IDLE, WAIT, DONE, ERR.
- IDLE: req=1 latches addr[1:0], ldtype and mem_addr.
  - If the request is legal, go to WAIT.
  - If ldtype is illegal, or LW with addr[1:0]≠0, or LH/LHU with addr[0]≠0, go to ERR. No mem_rd is issued.
- WAIT: mem_rd=1. A timeout counter starts at 0 on entry and increments each WAIT cycle.
  - mem_ack=1 at an edge: register the extracted result into data and go to DONE.
  - Otherwise, if the counter reaches TIMEOUT−1, go to ERR.
- DONE: done=1 for one cycle, then go to IDLE.
- ERR: err=1 for one cycle, then go to IDLE. data is not modified.
- Extraction is big-endian. Byte offset 0 maps to mem_rdata[31:24], offset 3 to [7:0]. Halfword offset 0 maps to [31:16], offset 2 to [15:0].
- LB/LH sign-extend to 32 bits. LBU/LHU zero-extend. LW passes the word unchanged.
- Boundary rules:
  - req in WAIT/DONE/ERR is ignored. It is not queued.
  - mem_ack outside WAIT is ignored.
  - mem_ack on the same edge as the timeout: ack wins and the load completes with done.
  - Reset in any state: state goes to IDLE, mem_rd and busy drop immediately (asynchronously). The in-flight load is discarded.

## Timing
- Reset values: busy=0, done=0, err=0, data=32'h0, mem_addr=32'h0, mem_rd=0, state IDLE, counter 0.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- Legal request:
  - req sampled at edge 0.
  - mem_rd=1 and busy=1 from cycle 1.
  - With ack sampled at edge k (k≥1), done=1 and data is valid in cycle k+1.
  - Minimum latency is 2 cycles with zero-wait memory.
  - IDLE is re-entered at edge k+2; the next req is accepted at that edge or later.
- Illegal request: req at edge 0 → err=1 in cycle 1, IDLE at edge 2. mem_rd never rises.
- Timeout: with no ack, mem_rd is high for exactly TIMEOUT cycles. err=1 in the following cycle.
- mem_addr stays constant from entry to WAIT until the return to IDLE.

## Test plan
- Reset then idle: assert rst mid-cycle → all outputs 0 immediately. Hold 10 cycles with req=0 → busy stays 0, mem_rd stays 0.
- LW zero-wait: addr=0x100, ldtype=000, mem_rdata=0xDEADBEEF, ack in first WAIT cycle → mem_addr=0x100, done pulse in cycle 2, data=0xDEADBEEF.
- Sub-word extraction: mem_rdata=0x80F17F01 with a 3-cycle ack delay →
  - LB @+0 → 0xFFFFFF80.
  - LBU @+1 → 0x000000F1.
  - LB @+2 → 0x0000007F.
  - LH @+2 → 0x00007F01.
  - LHU @+0 → 0x000080F1.
- Rejects: LW addr=0x102, LH addr=0x101, ldtype=110 → each gives an err pulse in cycle 1, mem_rd=0 throughout, data unchanged.
- Timeout and race with TIMEOUT=4:
  - No ack → mem_rd high exactly 4 cycles, then err.
  - ack on the 4th WAIT cycle → done, no err.
- Reset mid-load: rst asserted during WAIT → mem_rd drops immediately, no done/err. A following LW completes normally.
